hoplite_node_interface: RTL and testbench

//  Network-side endpoint of the processor MMIO message port. Packs processor writes
//  (coords, message words, packet-complete strobe) into flits for Hoplite router injection.

---
 rtl/hoplite_nic_pkg.sv | 24 ++
 rtl/hoplite_node_interface_if.sv | 62 ++++++
 rtl/hoplite_nic_fifo.sv | 61 ++++++
 rtl/hoplite_node_interface.sv | 193 +++++++++++++++++++
 tb/tb_hoplite_node_interface.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hoplite_nic_pkg.sv
// Shared definitions for the Hoplite node interface: flit field offsets,
// flit width helper and TX staging state encodings.
package hoplite_nic_pkg;

    localparam int DATA_W   = 32;
    localparam int DATA_LSB = 0;
    localparam int LAST_BIT = 32;
    localparam int Y_LSB    = 33;

    // Flit layout, MSB first: {x[cb], y[cb], last, data[32]}
    function automatic int X_LSB(input int cb);
        return Y_LSB + cb;
    endfunction

    function automatic int FLIT_WIDTH(input int cb);
        return DATA_W + 1 + 2 * cb;
    endfunction

    typedef enum logic {
        STAGE_EMPTY  = 1'b0,
        STAGE_STAGED = 1'b1
    } stage_e;

endpackage

// File: rtl/hoplite_node_interface_if.sv
// Bundle between the processor MMIO port / router and the node interface.
// slave: node interface side. master: processor + router side.
// Optional stat_* counters exist only with HOPLITE_NIC_STATS_EN defined.
interface hoplite_node_interface_if #(
    parameter int COORD_BITS = 1
);
    localparam int FW = hoplite_nic_pkg::FLIT_WIDTH(COORD_BITS);

    logic [COORD_BITS-1:0] x_coord_in;
    logic                  x_coord_in_valid;
    logic [COORD_BITS-1:0] y_coord_in;
    logic                  y_coord_in_valid;
    logic [31:0]           message_in;
    logic                  message_in_valid;
    logic                  packet_complete;
    logic                  message_out_ready;
    logic [31:0]           message_out;
    logic                  message_out_valid;
    logic                  message_available;
    logic                  message_read;
    logic                  message_done;
    logic [FW-1:0]         net_tx_flit;
    logic                  net_tx_valid;
    logic                  net_tx_ready;
    logic [FW-1:0]         net_rx_flit;
    logic                  net_rx_valid;
    logic                  net_rx_ready;
`ifdef HOPLITE_NIC_STATS_EN
    logic [31:0]           stat_tx_flits;
    logic [31:0]           stat_rx_flits;
    logic [31:0]           stat_tx_drops;
`endif

    modport slave (
        input  x_coord_in, x_coord_in_valid,
        input  y_coord_in, y_coord_in_valid,
        input  message_in, message_in_valid,
        input  packet_complete, message_read, message_done,
        input  net_tx_ready, net_rx_flit, net_rx_valid,
`ifdef HOPLITE_NIC_STATS_EN
        output stat_tx_flits, stat_rx_flits, stat_tx_drops,
`endif
        output message_out_ready, message_out, message_out_valid,
        output message_available, net_tx_flit, net_tx_valid,
        output net_rx_ready
    );

    modport master (
        output x_coord_in, x_coord_in_valid,
        output y_coord_in, y_coord_in_valid,
        output message_in, message_in_valid,
        output packet_complete, message_read, message_done,
        output net_tx_ready, net_rx_flit, net_rx_valid,
`ifdef HOPLITE_NIC_STATS_EN
        input  stat_tx_flits, stat_rx_flits, stat_tx_drops,
`endif
        input  message_out_ready, message_out, message_out_valid,
        input  message_available, net_tx_flit, net_tx_valid,
        input  net_rx_ready
    );

endinterface

// File: rtl/hoplite_nic_fifo.sv
// Synchronous first-word-fall-through FIFO with an optional second write
// per cycle (i_push2, written after i_din, only together with i_push).
// Ports: i_push/i_din, i_push2/i_din2, i_pop -> o_dout, o_empty, o_count.
module hoplite_nic_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_push2,
    input  logic [WIDTH-1:0]       i_din2,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic [AW-1:0]    w_wr1;
    logic [AW+1:0]    w_room;
    logic             w_pop;
    logic             w_wa;
    logic             w_wb;

    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    // Head is forced to zero when empty so outputs are clean after reset
    assign o_dout  = o_empty ? '0 : r_mem[r_rd];

    assign w_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees its slot for this cycle's write
    assign w_room = (AW+2)'(DEPTH) - (AW+2)'(r_cnt) + (AW+2)'(w_pop);
    assign w_wa   = i_push && (w_room != '0);
    assign w_wb   = w_wa && i_push2 && (w_room >= (AW+2)'(2));
    assign w_wr1  = r_wr + AW'(1);

    always_ff @(posedge clk) begin
        if (w_wa) r_mem[r_wr] <= i_din;
        if (w_wb) r_mem[w_wr1] <= i_din2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_wa) + AW'(w_wb);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_wa) + (AW+1)'(w_wb)
                     - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/hoplite_node_interface.sv
// Hoplite network endpoint: packs processor words into flits for injection
// and buffers ejected flits for processor reads with per-packet tracking.
// Ports: clk, reset (async, active-high), bus (hoplite_node_interface_if.slave).
// Option: HOPLITE_NIC_STATS_EN adds stat_tx_flits/stat_rx_flits/stat_tx_drops.
module hoplite_node_interface
    import hoplite_nic_pkg::*;
#(
    parameter int COORD_BITS = 1,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input logic                     clk,
    input logic                     reset,
    hoplite_node_interface_if.slave bus
);
    localparam int CB  = COORD_BITS;
    localparam int FW  = FLIT_WIDTH(COORD_BITS);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic [CB-1:0]     r_x;
    logic [CB-1:0]     r_y;
    logic [CB-1:0]     r_sx;
    logic [CB-1:0]     r_sy;
    logic [DATA_W-1:0] r_sd;
    stage_e            r_state;
    stage_e            w_next;
    logic [15:0]       r_pkt_cnt;
    logic [15:0]       w_pkt_nxt;
    logic              r_avail;

    logic              w_ready;
    logic              w_word;
    logic              w_push;
    logic              w_push2;
    logic [FW-1:0]     w_fa;
    logic [FW-1:0]     w_fb;
    logic [FW-1:0]     w_new;
    logic [FW-1:0]     w_tx_dout;
    logic              w_tx_empty;
    logic [TCW-1:0]    w_tx_cnt;
    logic              w_tx_pop;
    logic [DATA_W-1:0] w_rx_dout;
    logic              w_rx_empty;
    logic [RCW-1:0]    w_rx_cnt;
    logic              w_rx_full;
    logic              w_rx_acc;
    logic              w_inc;

    // Two free slots: a same-cycle word+complete pushes two flits
    assign w_ready = (w_tx_cnt <= TCW'(TX_DEPTH - 2));
    assign w_word  = bus.message_in_valid && w_ready;
    assign w_new   = {r_x, r_y, 1'b1, bus.message_in};

    always_comb begin
        w_push  = 1'b0;
        w_push2 = 1'b0;
        w_fa    = '0;
        w_fb    = '0;
        w_next  = r_state;
        unique case (r_state)
            STAGE_EMPTY: begin
                if (w_word && bus.packet_complete) begin
                    w_push = 1'b1;
                    w_fa   = w_new;
                end else if (w_word) begin
                    w_next = STAGE_STAGED;
                end
            end
            STAGE_STAGED: begin
                if (w_word) begin
                    w_push = 1'b1;
                    w_fa   = {r_sx, r_sy, 1'b0, r_sd};
                    if (bus.packet_complete) begin
                        w_push2 = 1'b1;
                        w_fb    = w_new;
                        w_next  = STAGE_EMPTY;
                    end
                end else if (bus.packet_complete) begin
                    w_push = 1'b1;
                    w_fa   = {r_sx, r_sy, 1'b1, r_sd};
                    w_next = STAGE_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_sd    <= '0;
            r_state <= STAGE_EMPTY;
        end else begin
            if (bus.x_coord_in_valid) r_x <= bus.x_coord_in;
            if (bus.y_coord_in_valid) r_y <= bus.y_coord_in;
            // Coordinates are captured with the word, not at push time
            if (w_word) begin
                r_sx <= r_x;
                r_sy <= r_y;
                r_sd <= bus.message_in;
            end
            r_state <= w_next;
        end
    end

    assign w_tx_pop = !w_tx_empty && bus.net_tx_ready;

    hoplite_nic_fifo #(.WIDTH(FW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_fa),
        .i_push2 (w_push2),
        .i_din2  (w_fb),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_dout),
        .o_empty (w_tx_empty),
        .o_count (w_tx_cnt)
    );

    assign w_rx_full = (w_rx_cnt == RCW'(RX_DEPTH));
    assign w_rx_acc  = bus.net_rx_valid && !w_rx_full;
    assign w_inc     = w_rx_acc && bus.net_rx_flit[LAST_BIT];

    hoplite_nic_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_acc),
        .i_din   (bus.net_rx_flit[DATA_W-1:0]),
        .i_push2 (1'b0),
        .i_din2  ('0),
        .i_pop   (bus.message_read),
        .o_dout  (w_rx_dout),
        .o_empty (w_rx_empty),
        .o_count (w_rx_cnt)
    );

    // Packet arrival and packet done in one cycle cancel out
    always_comb begin
        w_pkt_nxt = r_pkt_cnt;
        if (w_inc && !bus.message_done)
            w_pkt_nxt = r_pkt_cnt + 16'd1;
        else if (!w_inc && bus.message_done && r_pkt_cnt != '0)
            w_pkt_nxt = r_pkt_cnt - 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt <= '0;
            r_avail   <= 1'b0;
        end else begin
            r_pkt_cnt <= w_pkt_nxt;
            r_avail   <= (w_pkt_nxt != '0);
        end
    end

    assign bus.message_out_ready = w_ready;
    assign bus.net_tx_flit       = w_tx_dout;
    assign bus.net_tx_valid      = !w_tx_empty;
    assign bus.net_rx_ready      = !w_rx_full;
    assign bus.message_out       = w_rx_dout;
    assign bus.message_out_valid = !w_rx_empty;
    assign bus.message_available = r_avail;

`ifdef HOPLITE_NIC_STATS_EN
    logic [31:0] r_st_tx;
    logic [31:0] r_st_rx;
    logic [31:0] r_st_drop;
    logic        w_drop;

    assign w_drop = bus.message_in_valid && !w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st_tx   <= '0;
            r_st_rx   <= '0;
            r_st_drop <= '0;
        end else begin
            if (w_tx_pop) r_st_tx <= r_st_tx + 32'd1;
            if (w_rx_acc) r_st_rx <= r_st_rx + 32'd1;
            if (w_drop) r_st_drop <= r_st_drop + 32'd1;
        end
    end

    assign bus.stat_tx_flits = r_st_tx;
    assign bus.stat_rx_flits = r_st_rx;
    assign bus.stat_tx_drops = r_st_drop;
`endif

endmodule

// File: tb/tb_hoplite_node_interface.sv
// Self-checking bench for hoplite_node_interface: TX packing, back-pressure,
// RX packet tracking, RX full handling and reset mid-packet.
module tb_hoplite_node_interface;
    localparam int CB  = 1;
    localparam int TXD = 8;
    localparam int RXD = 8;
    localparam int FW  = 33 + 2 * CB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [FW-1:0] exp_tx[$];
    logic [31:0]   exp_rx[$];

    hoplite_node_interface_if #(.COORD_BITS(CB)) bus();

    hoplite_node_interface #(
        .COORD_BITS (CB),
        .TX_DEPTH   (TXD),
        .RX_DEPTH   (RXD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [CB-1:0] x,
                                         input logic [CB-1:0] y,
                                         input logic l,
                                         input logic [31:0] d);
        return {x, y, l, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coord(input logic [CB-1:0] x, input logic [CB-1:0] y);
        bus.x_coord_in = x;
        bus.y_coord_in = y;
        bus.x_coord_in_valid = 1'b1;
        bus.y_coord_in_valid = 1'b1;
        tick();
        bus.x_coord_in_valid = 1'b0;
        bus.y_coord_in_valid = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic c);
        bus.message_in = d;
        bus.message_in_valid = v;
        bus.packet_complete = c;
        tick();
        bus.message_in_valid = 1'b0;
        bus.packet_complete = 1'b0;
    endtask

    task automatic inject(input logic [31:0] d, input logic l);
        bus.net_rx_flit = {{(2*CB){1'b0}}, l, d};
        bus.net_rx_valid = 1'b1;
        tick();
        bus.net_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_vec++;
        if ({bus.message_out_ready, bus.net_rx_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_ready got %b want 11",
                     {bus.message_out_ready, bus.net_rx_ready});
        end
        n_vec++;
        if ({bus.net_tx_valid, bus.message_out_valid,
             bus.message_available} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_valids got %b want 000",
                     {bus.net_tx_valid, bus.message_out_valid,
                      bus.message_available});
        end
        n_vec++;
        if (bus.net_tx_flit !== '0 || bus.message_out !== '0) begin
            n_err++;
            $display("FAIL reset_data got %h/%h want 0/0",
                     bus.net_tx_flit, bus.message_out);
        end
`ifdef HOPLITE_NIC_STATS_EN
        n_vec++;
        if ({bus.stat_tx_flits, bus.stat_rx_flits, bus.stat_tx_drops} !== '0) begin
            n_err++;
            $display("FAIL reset_stats got %h %h %h want 0",
                     bus.stat_tx_flits, bus.stat_rx_flits, bus.stat_tx_drops);
        end
`endif
    endtask

    task automatic test_basic();
        logic [FW-1:0] f;
        bus.net_tx_ready = 1'b0;
        set_coord(1'b1, 1'b0);
        drive(1'b1, 32'hA, 1'b0);
        n_vec++;
        if (bus.message_out_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ready_a got %b want 1", bus.message_out_ready);
        end
        drive(1'b1, 32'hB, 1'b0);
        exp_tx.push_back(mk(1'b1, 1'b0, 1'b0, 32'hA));
        drive(1'b0, 32'h0, 1'b1);
        exp_tx.push_back(mk(1'b1, 1'b0, 1'b1, 32'hB));
        n_vec++;
        if (bus.message_out_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ready_b got %b want 1", bus.message_out_ready);
        end
        bus.net_tx_ready = 1'b1;
        for (int c = 0; c < 40 && exp_tx.size() != 0; c++) begin
            if (bus.net_tx_valid) begin
                n_vec++;
                f = exp_tx.pop_front();
                if (bus.net_tx_flit !== f) begin
                    n_err++;
                    $display("FAIL basic_flit got %h want %h", bus.net_tx_flit, f);
                end
            end
            tick();
        end
        n_vec++;
        if (exp_tx.size() != 0 || bus.net_tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drain left %0d valid %b want 0 0",
                     exp_tx.size(), bus.net_tx_valid);
            exp_tx.delete();
        end
`ifdef HOPLITE_NIC_STATS_EN
        n_vec++;
        if (bus.stat_tx_flits !== 32'd2) begin
            n_err++;
            $display("FAIL basic_stat_tx got %0d want 2", bus.stat_tx_flits);
        end
`endif
        bus.net_tx_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic          er;
        logic [FW-1:0] f;
        bus.net_tx_ready = 1'b0;
        for (int i = 0; i < TXD + 1; i++) begin
            er = (i < TXD);
            n_vec++;
            if (bus.message_out_ready !== er) begin
                n_err++;
                $display("FAIL bp_ready[%0d] got %b want %b",
                         i, bus.message_out_ready, er);
            end
            drive(1'b1, 32'h100 + i, 1'b0);
        end
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < TXD - 1; i++)
            exp_tx.push_back(mk(1'b1, 1'b0, 1'b0, 32'h100 + i));
        exp_tx.push_back(mk(1'b1, 1'b0, 1'b1, 32'h100 + TXD - 1));
`ifdef HOPLITE_NIC_STATS_EN
        n_vec++;
        if (bus.stat_tx_drops !== 32'd1) begin
            n_err++;
            $display("FAIL bp_drops got %0d want 1", bus.stat_tx_drops);
        end
`endif
        bus.net_tx_ready = 1'b1;
        for (int c = 0; c < 60 && exp_tx.size() != 0; c++) begin
            if (bus.net_tx_valid) begin
                n_vec++;
                f = exp_tx.pop_front();
                if (bus.net_tx_flit !== f) begin
                    n_err++;
                    $display("FAIL bp_flit got %h want %h", bus.net_tx_flit, f);
                end
            end
            tick();
        end
        n_vec++;
        if (exp_tx.size() != 0 || bus.net_tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain left %0d valid %b want 0 0",
                     exp_tx.size(), bus.net_tx_valid);
            exp_tx.delete();
        end
        n_vec++;
        if (bus.message_out_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_after got %b want 1", bus.message_out_ready);
        end
        bus.net_tx_ready = 1'b0;
    endtask

    task automatic test_rx_packet();
        logic [31:0] e;
        logic        ea;
        for (int i = 0; i < 3; i++) begin
            inject(32'h11 * (i + 1), i == 2);
            exp_rx.push_back(32'h11 * (i + 1));
            ea = (i == 2);
            n_vec++;
            if (bus.message_available !== ea) begin
                n_err++;
                $display("FAIL rx_avail[%0d] got %b want %b",
                         i, bus.message_available, ea);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            e = exp_rx.pop_front();
            if (bus.message_out_valid !== 1'b1 || bus.message_out !== e) begin
                n_err++;
                $display("FAIL rx_data[%0d] got %b/%h want 1/%h",
                         i, bus.message_out_valid, bus.message_out, e);
            end
            bus.message_read = 1'b1;
            tick();
            bus.message_read = 1'b0;
        end
        bus.message_done = 1'b1;
        tick();
        bus.message_done = 1'b0;
        n_vec++;
        if (bus.message_available !== 1'b0 || bus.message_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rx_done got %b/%b want 0/0",
                     bus.message_available, bus.message_out_valid);
        end
        bus.message_read = 1'b1;
        bus.message_done = 1'b1;
        tick();
        bus.message_read = 1'b0;
        bus.message_done = 1'b0;
        inject(32'h77, 1'b1);
        n_vec++;
        if (bus.message_available !== 1'b1 || bus.message_out !== 32'h77) begin
            n_err++;
            $display("FAIL rx_sat got %b/%h want 1/00000077",
                     bus.message_available, bus.message_out);
        end
        bus.message_read = 1'b1;
        bus.message_done = 1'b1;
        tick();
        bus.message_read = 1'b0;
        bus.message_done = 1'b0;
        n_vec++;
        if (bus.message_available !== 1'b0) begin
            n_err++;
            $display("FAIL rx_sat_done got %b want 0", bus.message_available);
        end
    endtask

    task automatic test_rx_full();
        logic [31:0] e;
        for (int i = 0; i < RXD; i++) begin
            inject(32'h40 + i, 1'b0);
            exp_rx.push_back(32'h40 + i);
        end
        n_vec++;
        if (bus.net_rx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready got %b want 0", bus.net_rx_ready);
        end
        inject(32'h48, 1'b0);
        n_vec++;
        e = exp_rx.pop_front();
        if (bus.message_out !== e) begin
            n_err++;
            $display("FAIL full_head got %h want %h", bus.message_out, e);
        end
        bus.message_read = 1'b1;
        tick();
        bus.message_read = 1'b0;
        n_vec++;
        e = exp_rx.pop_front();
        if (bus.net_rx_ready !== 1'b1 || bus.message_out !== e) begin
            n_err++;
            $display("FAIL full_pop got %b/%h want 1/%h",
                     bus.net_rx_ready, bus.message_out, e);
        end
        bus.message_read = 1'b1;
        bus.net_rx_flit = {{(2*CB){1'b0}}, 1'b0, 32'h49};
        bus.net_rx_valid = 1'b1;
        tick();
        bus.message_read = 1'b0;
        bus.net_rx_valid = 1'b0;
        exp_rx.push_back(32'h49);
        n_vec++;
        if (bus.net_rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_rw_ready got %b want 1", bus.net_rx_ready);
        end
        inject(32'h4A, 1'b0);
        exp_rx.push_back(32'h4A);
        n_vec++;
        if (bus.net_rx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_refill got %b want 0", bus.net_rx_ready);
        end
        for (int i = 0; i < RXD; i++) begin
            n_vec++;
            e = exp_rx.pop_front();
            if (bus.message_out !== e) begin
                n_err++;
                $display("FAIL full_drain[%0d] got %h want %h",
                         i, bus.message_out, e);
            end
            bus.message_read = 1'b1;
            tick();
            bus.message_read = 1'b0;
        end
        n_vec++;
        if (bus.message_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_empty got %b want 0", bus.message_out_valid);
        end
`ifdef HOPLITE_NIC_STATS_EN
        n_vec++;
        if (bus.stat_rx_flits !== 32'd14) begin
            n_err++;
            $display("FAIL full_stat_rx got %0d want 14", bus.stat_rx_flits);
        end
`endif
    endtask

    task automatic test_complete_cases();
        logic [FW-1:0] f;
        bus.net_tx_ready = 1'b0;
        set_coord(1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        n_vec++;
        if (bus.net_tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cmp_empty got %b want 0", bus.net_tx_valid);
        end
        drive(1'b1, 32'hC, 1'b1);
        exp_tx.push_back(mk(1'b0, 1'b1, 1'b1, 32'hC));
        drive(1'b1, 32'hD, 1'b0);
        set_coord(1'b1, 1'b1);
        drive(1'b1, 32'hE, 1'b1);
        exp_tx.push_back(mk(1'b0, 1'b1, 1'b0, 32'hD));
        exp_tx.push_back(mk(1'b1, 1'b1, 1'b1, 32'hE));
        bus.net_tx_ready = 1'b1;
        for (int c = 0; c < 40 && exp_tx.size() != 0; c++) begin
            if (bus.net_tx_valid) begin
                n_vec++;
                f = exp_tx.pop_front();
                if (bus.net_tx_flit !== f) begin
                    n_err++;
                    $display("FAIL cmp_flit got %h want %h", bus.net_tx_flit, f);
                end
            end
            tick();
        end
        n_vec++;
        if (exp_tx.size() != 0 || bus.net_tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cmp_drain left %0d valid %b want 0 0",
                     exp_tx.size(), bus.net_tx_valid);
            exp_tx.delete();
        end
`ifdef HOPLITE_NIC_STATS_EN
        n_vec++;
        if (bus.stat_tx_flits !== 32'd13) begin
            n_err++;
            $display("FAIL cmp_stat_tx got %0d want 13", bus.stat_tx_flits);
        end
`endif
        bus.net_tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.net_tx_ready = 1'b0;
        drive(1'b1, 32'hF0, 1'b0);
        drive(1'b1, 32'hF1, 1'b0);
        drive(1'b1, 32'hF2, 1'b0);
        inject(32'h55, 1'b1);
        n_vec++;
        if (bus.net_tx_valid !== 1'b1 || bus.message_available !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre got %b/%b want 1/1",
                     bus.net_tx_valid, bus.message_available);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.net_tx_valid, bus.message_out_valid, bus.message_available,
             bus.message_out_ready, bus.net_rx_ready} !== 5'b00011) begin
            n_err++;
            $display("FAIL rst_async got %b want 00011",
                     {bus.net_tx_valid, bus.message_out_valid,
                      bus.message_available, bus.message_out_ready,
                      bus.net_rx_ready});
        end
        tick();
        reset = 1'b0;
        tick();
        drive(1'b0, 32'h0, 1'b1);
        n_vec++;
        if (bus.net_tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_staged got %b want 0", bus.net_tx_valid);
        end
    endtask

    initial begin
        bus.x_coord_in       = '0;
        bus.x_coord_in_valid = 1'b0;
        bus.y_coord_in       = '0;
        bus.y_coord_in_valid = 1'b0;
        bus.message_in       = '0;
        bus.message_in_valid = 1'b0;
        bus.packet_complete  = 1'b0;
        bus.message_read     = 1'b0;
        bus.message_done     = 1'b0;
        bus.net_tx_ready     = 1'b0;
        bus.net_rx_flit      = '0;
        bus.net_rx_valid     = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_rx_packet();
        test_rx_full();
        test_complete_cases();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
